// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared writeback definitions: widths, the writeback entry record, and the
// grant encoding used by the writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int XLEN               = 32;
  localparam int REG_ADDR_W         = 5;
  localparam int NUM_REGS           = 2 ** REG_ADDR_W;
  localparam int MAX_STREAK_DEFAULT = 3;
  localparam int STREAK_W           = 4;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_ALU  = 2'd1,
    GRANT_LSU  = 2'd2
  } grant_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_hold_slot.sv
// One-entry holding register for a writeback producer. Ready passes the
// grant straight through so a source can stream one result per cycle.
module regfile_wb_arbiter_wb_hold_slot #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  src_valid,
  input  logic [REG_ADDR_W-1:0] src_rd,
  input  logic [XLEN-1:0]       src_data,
  output logic                  src_ready,
  input  logic                  grant,
  output logic                  hold_valid,
  output logic [REG_ADDR_W-1:0] hold_rd,
  output logic [XLEN-1:0]       hold_data
);

  assign src_ready = !hold_valid || grant;

  // Load on handshake (a same-cycle grant of the old entry is implied), else clear on grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_rd    <= '0;
      hold_data  <= '0;
    end else if (src_valid && src_ready) begin
      hold_valid <= 1'b1;
      hold_rd    <= src_rd;
      hold_data  <= src_data;
    end else if (grant) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback driver: merges ALU and LSU results through two
// holding slots, arbitrates with LSU priority bounded by a starvation streak,
// suppresses x0 writes and exports the pending-destination mask.
module regfile_wb_arbiter #(
  parameter int XLEN       = regfile_wb_arbiter_pkg::XLEN,
  parameter int REG_ADDR_W = regfile_wb_arbiter_pkg::REG_ADDR_W,
  parameter int MAX_STREAK = regfile_wb_arbiter_pkg::MAX_STREAK_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  input  logic [REG_ADDR_W-1:0]      alu_rd,
  input  logic [XLEN-1:0]            alu_data,
  output logic                       alu_ready,
  input  logic                       lsu_valid,
  input  logic [REG_ADDR_W-1:0]      lsu_rd,
  input  logic [XLEN-1:0]            lsu_data,
  output logic                       lsu_ready,
  output logic                       wEn,
  output logic [REG_ADDR_W-1:0]      rd,
  output logic [XLEN-1:0]            write_data,
  output logic [2**REG_ADDR_W-1:0]   pending_mask
);
  import regfile_wb_arbiter_pkg::*;

  localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_STREAK);

  logic                  alu_hold_valid;
  logic [REG_ADDR_W-1:0] alu_hold_rd;
  logic [XLEN-1:0]       alu_hold_data;
  logic                  lsu_hold_valid;
  logic [REG_ADDR_W-1:0] lsu_hold_rd;
  logic [XLEN-1:0]       lsu_hold_data;

  grant_e                grant;
  logic [STREAK_W-1:0]   streak;
  logic [STREAK_W-1:0]   streak_next;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;

  regfile_wb_arbiter_wb_hold_slot #(
    .XLEN       (XLEN),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_alu_slot (
    .clk        (clk),
    .rst        (rst),
    .src_valid  (alu_valid),
    .src_rd     (alu_rd),
    .src_data   (alu_data),
    .src_ready  (alu_ready),
    .grant      (grant == GRANT_ALU),
    .hold_valid (alu_hold_valid),
    .hold_rd    (alu_hold_rd),
    .hold_data  (alu_hold_data)
  );

  regfile_wb_arbiter_wb_hold_slot #(
    .XLEN       (XLEN),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_lsu_slot (
    .clk        (clk),
    .rst        (rst),
    .src_valid  (lsu_valid),
    .src_rd     (lsu_rd),
    .src_data   (lsu_data),
    .src_ready  (lsu_ready),
    .grant      (grant == GRANT_LSU),
    .hold_valid (lsu_hold_valid),
    .hold_rd    (lsu_hold_rd),
    .hold_data  (lsu_hold_data)
  );

  // Grant selection: LSU wins contention until the ALU has waited MAX_STREAK grants.
  always_comb begin
    grant = GRANT_NONE;
    if (alu_hold_valid && lsu_hold_valid) begin
      grant = (streak < MAX_S) ? GRANT_LSU : GRANT_ALU;
    end else if (alu_hold_valid) begin
      grant = GRANT_ALU;
    end else if (lsu_hold_valid) begin
      grant = GRANT_LSU;
    end
  end

  // Streak counts LSU grants taken while an ALU result waits; anything else resets it.
  always_comb begin
    streak_next = '0;
    if (grant == GRANT_LSU && alu_hold_valid) begin
      streak_next = (streak >= MAX_S) ? MAX_S : streak + 1'b1;
    end
  end

  // Route the granted slot to the output register.
  always_comb begin
    sel_rd   = lsu_hold_rd;
    sel_data = lsu_hold_data;
    if (grant == GRANT_ALU) begin
      sel_rd   = alu_hold_rd;
      sel_data = alu_hold_data;
    end
  end

  // Streak register.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else begin
      streak <= streak_next;
    end
  end

  // Write-port register; rd/data hold when idle, x0 is consumed without enabling the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      wEn        <= 1'b0;
      rd         <= '0;
      write_data <= '0;
    end else if (grant != GRANT_NONE) begin
      wEn        <= (sel_rd != '0);
      rd         <= sel_rd;
      write_data <= sel_data;
    end else begin
      wEn        <= 1'b0;
    end
  end

  // Destinations still owed to the register file: both slots plus the write port.
  always_comb begin
    pending_mask = '0;
    if (alu_hold_valid) pending_mask[alu_hold_rd] = 1'b1;
    if (lsu_hold_valid) pending_mask[lsu_hold_rd] = 1'b1;
    if (wEn)            pending_mask[rd]          = 1'b1;
    pending_mask[0] = 1'b0;
  end

endmodule
